// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer, so in_ready depends only on local state.
// It also keeps a saturating count of the cycles in which the memory side stalls.
module ex_mem_pipe_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_mem,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0]   main_alu_q, skid_alu_q;
    logic [DATA_W-1:0]   main_mem_q, skid_mem_q;
    logic [CNT_W-1:0]    stall_q;

    logic accept, take;
    logic ld_main_in, ld_main_skid, ld_skid;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        // Flush wins over everything, including any load this cycle.
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d    = StBusy;
                        ld_main_in = 1'b1;
                    end
                end
                StBusy: begin
                    if (accept && take) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_d = StFull;
                        ld_skid = 1'b1;
                    end else if (take) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (take) begin
                        state_d      = StBusy;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_alu_q  <= '0;
            main_mem_q  <= '0;
            skid_ctrl_q <= '0;
            skid_alu_q  <= '0;
            skid_mem_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_main_in) begin
                main_ctrl_q <= in_ctrl;
                main_alu_q  <= in_alu;
                main_mem_q  <= in_mem;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_alu_q  <= skid_alu_q;
                main_mem_q  <= skid_mem_q;
            end
            if (ld_skid) begin
                skid_ctrl_q <= in_ctrl;
                skid_alu_q  <= in_alu;
                skid_mem_q  <= in_mem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Bubbles carry no control bits; the data fields keep their last value.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_alu   = main_alu_q;
    assign out_mem   = main_mem_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: compares against a queue-based model of a two-deep FIFO.
// A second instance with a 4-bit counter shares the same stimulus and is used to check saturation.
module tb_ex_mem_pipe_stage;

    logic        clk, rst_n;
    logic        in_valid, flush, out_ready;
    logic [7:0]  in_ctrl;
    logic [15:0] in_alu, in_mem;

    logic        in_ready, out_valid;
    logic [7:0]  out_ctrl;
    logic [15:0] out_alu, out_mem, stall_cnt;

    logic        in_ready_s, out_valid_s;
    logic [7:0]  out_ctrl_s;
    logic [15:0] out_alu_s, out_mem_s;
    logic [3:0]  stall_cnt_s;

    ex_mem_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_mem(in_mem), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_alu(out_alu), .out_mem(out_mem), .stall_cnt(stall_cnt)
    );

    ex_mem_pipe_stage #(.DATA_W(16), .CTRL_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_mem(in_mem), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s),
        .out_alu(out_alu_s), .out_mem(out_mem_s), .stall_cnt(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  c;
        logic [15:0] a;
        logic [15:0] m;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] last_alu, last_mem;
    int unsigned stall_m, stall_s;
    int          total = 0;
    int          bad = 0;

    function automatic logic [41:0] exp_vec();
        logic ov;
        ov = (mq.size() > 0);
        return {ov, mq.size() < 2, ov ? mq[0].c : 8'h00, last_alu, last_mem};
    endfunction

    task automatic model_reset();
        mq.delete();
        last_alu = '0;
        last_mem = '0;
        stall_m  = 0;
        stall_s  = 0;
    endtask

    // Drives one cycle starting 1 time unit after a rising edge; returns 1 unit after the next.
    task automatic tick(input logic v, input logic [7:0] c, input logic [15:0] a,
                        input logic [15:0] m, input logic f, input logic r);
        ent_t e;
        logic acc, tk, ov;
        in_valid = v; in_ctrl = c; in_alu = a; in_mem = m; flush = f; out_ready = r;
        ov  = (mq.size() > 0);
        acc = v && (mq.size() < 2);
        tk  = ov && r;
        @(posedge clk);
        if (ov && !r && !f) begin
            if (stall_m != 65535) stall_m++;
            if (stall_s != 15) stall_s++;
        end
        if (f) begin
            mq.delete();
        end else begin
            if (tk) void'(mq.pop_front());
            if (acc) begin
                e.c = c; e.a = a; e.m = m;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) begin
            last_alu = mq[0].a;
            last_mem = mq[0].m;
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; flush = 0; out_ready = 0;
        in_ctrl = 0; in_alu = 0; in_mem = 0;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, in_ready, out_ctrl, out_alu, out_mem} !== {2'b01, 40'h0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h",
                     {out_valid, in_ready, out_ctrl, out_alu, out_mem}, {2'b01, 40'h0});
        end
        total++;
        if (stall_cnt !== 16'h0 || stall_cnt_s !== 4'h0) begin
            bad++;
            $display("FAIL reset_stall got=%h/%h want=0/0", stall_cnt, stall_cnt_s);
        end
    endtask

    task automatic test_single_pass();
        do_reset();
        tick(1, 8'h5A, 16'h1234, 16'hBEEF, 0, 1);
        total++;
        if ({out_valid, out_ctrl, out_alu, out_mem} !== {1'b1, 8'h5A, 16'h1234, 16'hBEEF}) begin
            bad++;
            $display("FAIL single_out got=%h want=%h", {out_valid, out_ctrl, out_alu, out_mem},
                     {1'b1, 8'h5A, 16'h1234, 16'hBEEF});
        end
        tick(0, 8'h00, 16'h0, 16'h0, 0, 1);
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            bad++;
            $display("FAIL single_bubble got=%b/%h want=0/00", out_valid, out_ctrl);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        tick(1, 8'h11, 16'h0001, 16'hA001, 0, 0);
        tick(1, 8'h22, 16'h0002, 16'hA002, 0, 0);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready_full got=%b want=0", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'h00, 16'h0, 16'h0, 0, 0);
            total++;
            if (stall_cnt !== 16'(stall_m) || stall_cnt !== 16'(i + 2)) begin
                bad++;
                $display("FAIL bp_stall got=%0d want=%0d", stall_cnt, i + 2);
            end
        end
        total++;
        if ({out_valid, out_alu} !== {1'b1, 16'h0001}) begin
            bad++;
            $display("FAIL bp_first_A got=%h want=%h", {out_valid, out_alu}, {1'b1, 16'h0001});
        end
        tick(0, 8'h00, 16'h0, 16'h0, 0, 1);
        total++;
        if ({out_valid, in_ready, out_ctrl, out_alu} !== {2'b11, 8'h22, 16'h0002}) begin
            bad++;
            $display("FAIL bp_then_B got=%h want=%h", {out_valid, in_ready, out_ctrl, out_alu},
                     {2'b11, 8'h22, 16'h0002});
        end
        tick(0, 8'h00, 16'h0, 16'h0, 0, 1);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_drained got=%b%b want=01", out_valid, in_ready);
        end
    endtask

    task automatic test_streaming();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick(1, 8'(i), 16'(i + 100), 16'(i), 0, 1);
            if (out_valid !== 1'b1 || out_alu !== 16'(i + 100) || in_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL stream_order got=%0d_bad_cycles want=0", errs);
        end
        total++;
        if (stall_cnt !== 16'h0) begin
            bad++;
            $display("FAIL stream_stall got=%0d want=0", stall_cnt);
        end
    endtask

    task automatic test_flush_full();
        int seen = 0;
        do_reset();
        tick(1, 8'h01, 16'hF001, 16'h0, 0, 0);
        tick(1, 8'h02, 16'hF002, 16'h0, 0, 0);
        tick(1, 8'h03, 16'hF003, 16'h0, 1, 0);
        total++;
        if ({out_valid, in_ready, out_ctrl} !== {2'b01, 8'h00}) begin
            bad++;
            $display("FAIL flush_state got=%h want=%h", {out_valid, in_ready, out_ctrl},
                     {2'b01, 8'h00});
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'h00, 16'h0, 16'h0, 0, 1);
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL flush_no_leak got=%0d want=0", seen);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 8'h0A, 16'hAAAA, 16'h1111, 0, 0);
        tick(1, 8'h0B, 16'hBBBB, 16'h2222, 0, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        total++;
        if ({out_valid, in_ready, out_ctrl, out_alu, out_mem, stall_cnt} !==
            {2'b01, 56'h0}) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h",
                     {out_valid, in_ready, out_ctrl, out_alu, out_mem, stall_cnt}, {2'b01, 56'h0});
        end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_hold got=%b want=0", out_valid);
        end
        rst_n = 1;
        tick(1, 8'h0C, 16'hCCCC, 16'h3333, 0, 1);
        total++;
        if ({out_valid, out_ctrl, out_alu, out_mem} !== {1'b1, 8'h0C, 16'hCCCC, 16'h3333}) begin
            bad++;
            $display("FAIL async_after got=%h want=%h", {out_valid, out_ctrl, out_alu, out_mem},
                     {1'b1, 8'h0C, 16'hCCCC, 16'h3333});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tick(1, 8'h77, 16'h7777, 16'h7777, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 8'h00, 16'h0, 16'h0, 0, 0);
        total++;
        if (stall_cnt_s !== 4'd15 || stall_cnt !== 16'd20) begin
            bad++;
            $display("FAIL saturation got=%0d/%0d want=15/20", stall_cnt_s, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [41:0] want;
        int          errs = 0;
        int          serrs = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            want = exp_vec();
            if ({out_valid, in_ready, out_ctrl, out_alu, out_mem} !== want ||
                {out_valid_s, in_ready_s, out_ctrl_s, out_alu_s, out_mem_s} !== want) begin
                if (errs == 0)
                    $display("FAIL random_outputs cycle=%0d got=%h want=%h", i,
                             {out_valid, in_ready, out_ctrl, out_alu, out_mem}, want);
                errs++;
            end
            if (stall_cnt !== 16'(stall_m) || stall_cnt_s !== 4'(stall_s)) serrs++;
        end
        total++;
        if (errs != 0) bad++;
        total++;
        if (serrs != 0) begin
            bad++;
            $display("FAIL random_stall got=%0d_bad_cycles want=0", serrs);
        end
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_single_pass();
        test_back_pressure();
        test_streaming();
        test_flush_full();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_stage.md
EX_MEM_PIPE_STAGE -- requirements
Module: ex_mem_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the ALU-result and memory-data payload fields.
REQ-002 SHALL have parameter CTRL_W, default 8, width of the packed control field (wbs, mm[1:0], wm, ni, wce, wme1, wme2).
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 SHALL have ports, in this order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream (execute) entry valid.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  control bits.
- in_alu  in  DATA_W  ALU result.
- in_mem  in  DATA_W  store data.
- flush  in  1  kill all held entries.
- out_valid  out  1  memory-side entry valid.
- out_ready  in  1  downstream (memory) accepts.
- out_ctrl  out  CTRL_W  control bits; zero when out_valid=0.
- out_alu  out  DATA_W  ALU result.
- out_mem  out  DATA_W  store data.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-006 SHALL define accept = in_valid & in_ready and take = out_valid & out_ready.
REQ-007 SHALL hold two entries: main (drives the outputs) and skid, each storing {ctrl, alu, mem}.
REQ-008 SHALL implement the FSM states EMPTY (no entry), BUSY (main only) and FULL (main and skid).
REQ-009 SHALL transition from EMPTY to BUSY on accept, with main loaded from the inputs.
REQ-010 SHALL, in BUSY:
- on accept & take, stay BUSY with main loaded from the inputs;
- on accept & !take, go to FULL with skid loaded from the inputs;
- on !accept & take, go to EMPTY;
- otherwise hold.
REQ-011 SHALL, in FULL:
- on take, go to BUSY with main loaded from skid;
- otherwise hold.
REQ-012 SHALL drive in_ready = (state != FULL) combinationally from state only, with no combinational path from out_ready or in_valid.
REQ-013 SHALL drive out_valid = (state != EMPTY).
REQ-014 SHALL force out_ctrl to zero whenever out_valid=0 (bubble); out_alu/out_mem SHALL then hold their last value.
REQ-015 SHALL give a latency of 1 cycle from accept in EMPTY to out_valid=1 with that payload.
REQ-016 SHALL preserve order: entries leave in acceptance order with no loss or duplication.
REQ-017 SHALL, on flush=1 at a clock edge, go to EMPTY regardless of state, discarding main, skid and any entry accepted that cycle; flush SHALL take priority over accept and take.
REQ-018 SHALL increment stall_cnt by 1 each cycle with out_valid=1 & out_ready=0 & flush=0, saturate at all-ones, and never wrap.
REQ-019 SHALL keep payload registers unchanged unless their load condition in REQ-009..REQ-011 holds.

Reset
REQ-020 SHALL, while rst_n=0, immediately set:
- state = EMPTY;
- out_valid = 0, out_ctrl = 0, in_ready = 1;
- out_alu = 0, out_mem = 0, skid = 0;
- stall_cnt = 0.
REQ-021 SHALL, on rst_n asserted mid-operation (BUSY or FULL), discard all entries without producing a take on the following cycles.
REQ-022 SHALL honour accept from the first rising edge after rst_n deasserts.

Verification
REQ-023 Single pass: EMPTY, out_ready=1, accept {ctrl=0x5A, alu=0x1234, mem=0xBEEF} -> next cycle out_valid=1 with those values; cycle after, out_valid=0 and out_ctrl=0x00.
REQ-024 Back-pressure: out_ready=0, push A=0x0001 then B=0x0002 -> in_ready=0 after B; stall_cnt increments each cycle; with out_ready=1, A then B emerge on consecutive cycles and in_ready returns to 1.
REQ-025 Streaming: in_valid=out_ready=1 for 100 cycles with incrementing alu -> exactly one entry out per cycle, in order, state never FULL, stall_cnt=0.
REQ-026 Flush in FULL with a simultaneous accept -> next cycle out_valid=0, out_ctrl=0, in_ready=1; none of the three entries ever appears.
REQ-027 Async reset: assert rst_n=0 between clock edges while in FULL -> outputs at reset values before the next edge; after release, a new entry C passes with 1-cycle latency.
REQ-028 Saturation: CNT_W=4, out_ready=0 for 20 cycles with an entry held -> stall_cnt stops at 15.
